pe_param: RTL and testbench
===========================

// Module: pe_param
// PURPOSE
//  Parametrised weight-stationary processing element for the systolic array.
//  Signed fixed-point MAC with double-buffered weights (shadow/active), switch
//  propagation and configurable multiplier pipelining. Generalises the Q8.8 PE.
//  One instance per array cell: input and valid flow right, psum flows down,
//  and weight, accept and switch flow down the column.
// PARAMETERS
//  DATA_W    16  signed width of input, weight and psum (two's complement)
//  FRAC_W    8   fractional bits (Q(DATA_W-FRAC_W).FRAC_W); 1 <= FRAC_W < DATA_W
//  MUL_PIPE  0   0: compute latency 1; 1: extra register after the multiplier (latency 2)
// PORTS
//  clk              in   1       clock, rising edge
//  rst              in   1       synchronous reset, active-high
//  pe_enabled       in   1       cell enable; 0 => compute outputs forced to 0
//  pe_valid_in      in   1       input/psum pair valid this cycle
//  pe_input_in      in   DATA_W  activation from left neighbour
//  pe_psum_in       in   DATA_W  partial sum from upper neighbour
//  pe_accept_w_in   in   1       load pe_weight_in into the shadow weight register
//  pe_weight_in     in   DATA_W  weight from upper neighbour
//  pe_switch_in     in   1       copy shadow weight into the active weight register
//  pe_ovf_clr_in    in   1       clear the sticky overflow flag
//  pe_valid_out     out  1       registered valid to right/down
//  pe_input_out     out  DATA_W  registered activation to right neighbour
//  pe_psum_out      out  DATA_W  MAC result to lower neighbour
//  pe_weight_out    out  DATA_W  registered weight to lower neighbour
//  pe_accept_w_out  out  1       registered accept to lower neighbour
//  pe_switch_out    out  1       registered switch to lower neighbour
//  pe_ovf_out       out  1       sticky overflow flag
// BEHAVIOUR
//  - Reset: all outputs, the shadow/active weights and the pipeline stages go to 0
//    on the next edge. Mid-operation reset discards in-flight results.
//  - Weight chain (latency 1, independent of pe_enabled):
//    accept_w=1 => shadow<=weight_in. weight_out<=weight_in, accept_w_out<=accept_w_in.
//  - Switch: switch_in=1 => active<=shadow at that edge; switch_out<=switch_in (1 cycle).
//    Simultaneous accept_w+switch: active takes the OLD shadow, shadow takes the new weight.
//  - Compute sees the active weight as it was before the edge. A switch takes effect
//    for the next cycle's valid data.
//  - MAC when valid_in & pe_enabled:
//    prod  = signed(input)*signed(active)   (2*DATA_W bits)
//    prodr = (prod + 2^(FRAC_W-1)) >>> FRAC_W   (round half toward +inf)
//    sum   = prodr + sign-extended psum_in, computed at 2*DATA_W+1 bits
//    Overflow: sum outside [-2^(DATA_W-1), 2^(DATA_W-1)-1].
//  - Data outputs valid_out, input_out and psum_out share latency L=1+MUL_PIPE, so
//    the array skew is unchanged. Non-valid cycles (valid_in=0 or pe_enabled=0):
//    valid_out=0, input_out=0, psum_out=0 at the corresponding output cycle.
//  - pe_ovf_out is set at the result cycle of any overflowing valid MAC. It is
//    cleared by rst or pe_ovf_clr_in; a set in the same cycle as a clear wins.
//  - With MUL_PIPE=1 the stage register holds the rounded product, psum_in, input and valid.
//    It advances every cycle, with no stall.
// CONFIGURATION
//  PE_SATURATE_EN defined: an overflowing sum is clamped to 2^(DATA_W-1)-1
//    or -2^(DATA_W-1).
//  PE_SATURATE_EN undefined: psum_out = sum[DATA_W-1:0] (wrap). The ovf flag
//    behaves identically in both builds.
// TESTING (DATA_W=16, FRAC_W=8 unless noted)
//  1 accept_w=1, weight=0x4500 (69.0), 1 edge -> shadow=0x4500, active=0x0000,
//    weight_out=0x4500, accept_w_out=1
//  2 accept_w=1 weight=0x0A00 together with switch=1 -> active=0x4500,
//    shadow=0x0A00, switch_out=1 next cycle
//  3 active=0x0180 (1.5), input=0xFE00 (-2.0), psum=0x0040 (0.25), valid=1
//    -> after L: psum_out=0xFD40 (-2.75), valid_out=1, input_out=0xFE00, ovf=0
//  4 active=0x4500, input=0x0200, psum=0x3200 (188.0 result) -> ovf=1.
//    Saturate build: psum_out=0x7FFF; wrap build: 0xBC00. ovf stays 1 until
//    pe_ovf_clr_in
//  5 Rounding: active=0x0001, input=0x0080, psum=0 -> psum_out=0x0001.
//    active=0x0001, input=0xFF80 -> psum_out=0x0000
//  6 MUL_PIPE=1: back-to-back valids, then rst asserted with data in flight ->
//    valid_out=0 at all cycles after the reset edge. pe_enabled=0 with valid=1
//    -> valid_out=0, psum_out=0, weight chain still forwards

Source files
------------

// File: rtl/pe_param.sv
// pe_param: weight-stationary systolic PE with signed fixed-point MAC, shadow/active weights
// and optional multiplier pipelining. Build macro PE_SATURATE_EN clamps overflowing sums.
module pe_param #(
  parameter int DATA_W   = 16,
  parameter int FRAC_W   = 8,
  parameter int MUL_PIPE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pe_enabled,
  input  logic              pe_valid_in,
  input  logic [DATA_W-1:0] pe_input_in,
  input  logic [DATA_W-1:0] pe_psum_in,
  input  logic              pe_accept_w_in,
  input  logic [DATA_W-1:0] pe_weight_in,
  input  logic              pe_switch_in,
  input  logic              pe_ovf_clr_in,
  output logic              pe_valid_out,
  output logic [DATA_W-1:0] pe_input_out,
  output logic [DATA_W-1:0] pe_psum_out,
  output logic [DATA_W-1:0] pe_weight_out,
  output logic              pe_accept_w_out,
  output logic              pe_switch_out,
  output logic              pe_ovf_out
);

  localparam int PW = 2*DATA_W + 1;
  localparam logic signed [PW-1:0] RND     = {{(PW-1){1'b0}}, 1'b1} << (FRAC_W-1);
  localparam logic signed [PW-1:0] SUM_MAX = {{(DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PW-1:0] SUM_MIN = {{(DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

  logic [DATA_W-1:0]          shadow_r;
  logic [DATA_W-1:0]          active_r;
  logic signed [2*DATA_W-1:0] in_x_s;
  logic signed [2*DATA_W-1:0] w_x_s;
  logic signed [2*DATA_W-1:0] prod_s;
  logic signed [PW-1:0]       prodr_s;
  logic                       mac_valid_s;
  logic                       st_valid_s;
  logic [DATA_W-1:0]          st_input_s;
  logic [DATA_W-1:0]          st_psum_s;
  logic signed [PW-1:0]       st_prodr_s;
  logic signed [PW-1:0]       sum_s;
  logic                       ovf_s;
  logic [DATA_W-1:0]          res_s;

  // Weight chain: shadow load, active switch and forwarding to the lower cell
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_r        <= {DATA_W{1'b0}};
      active_r        <= {DATA_W{1'b0}};
      pe_weight_out   <= {DATA_W{1'b0}};
      pe_accept_w_out <= 1'b0;
      pe_switch_out   <= 1'b0;
    end else begin
      // active takes the pre-edge shadow even when a new weight lands this edge
      if (pe_accept_w_in) shadow_r <= pe_weight_in;
      if (pe_switch_in)   active_r <= shadow_r;
      pe_weight_out   <= pe_weight_in;
      pe_accept_w_out <= pe_accept_w_in;
      pe_switch_out   <= pe_switch_in;
    end
  end

  // Multiply by the current active weight and round half toward +inf
  always_comb begin
    in_x_s      = {{DATA_W{pe_input_in[DATA_W-1]}}, pe_input_in};
    w_x_s       = {{DATA_W{active_r[DATA_W-1]}}, active_r};
    prod_s      = in_x_s * w_x_s;
    prodr_s     = ($signed({prod_s[2*DATA_W-1], prod_s}) + RND) >>> FRAC_W;
    mac_valid_s = pe_valid_in & pe_enabled;
  end

  generate
    if (MUL_PIPE != 0) begin : g_pipe
      logic                 pv_r;
      logic [DATA_W-1:0]    pin_r;
      logic [DATA_W-1:0]    pps_r;
      logic signed [PW-1:0] ppr_r;

      // Multiplier stage register, advances every cycle
      always_ff @(posedge clk) begin
        if (rst) begin
          pv_r  <= 1'b0;
          pin_r <= {DATA_W{1'b0}};
          pps_r <= {DATA_W{1'b0}};
          ppr_r <= {PW{1'b0}};
        end else begin
          pv_r  <= mac_valid_s;
          pin_r <= pe_input_in;
          pps_r <= pe_psum_in;
          ppr_r <= prodr_s;
        end
      end

      assign st_valid_s = pv_r;
      assign st_input_s = pin_r;
      assign st_psum_s  = pps_r;
      assign st_prodr_s = ppr_r;
    end else begin : g_nopipe
      assign st_valid_s = mac_valid_s;
      assign st_input_s = pe_input_in;
      assign st_psum_s  = pe_psum_in;
      assign st_prodr_s = prodr_s;
    end
  endgenerate

  // Accumulate at full width, detect overflow, then wrap or clamp
  always_comb begin
    sum_s = st_prodr_s + $signed({{(DATA_W+1){st_psum_s[DATA_W-1]}}, st_psum_s});
    ovf_s = st_valid_s && ((sum_s > SUM_MAX) || (sum_s < SUM_MIN));
`ifdef PE_SATURATE_EN
    if (ovf_s) begin
      res_s = sum_s[PW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      res_s = sum_s[DATA_W-1:0];
    end
`else
    res_s = sum_s[DATA_W-1:0];
`endif
  end

  // Data outputs and sticky overflow; a new overflow beats a clear
  always_ff @(posedge clk) begin
    if (rst) begin
      pe_valid_out <= 1'b0;
      pe_input_out <= {DATA_W{1'b0}};
      pe_psum_out  <= {DATA_W{1'b0}};
      pe_ovf_out   <= 1'b0;
    end else begin
      if (st_valid_s) begin
        pe_valid_out <= 1'b1;
        pe_input_out <= st_input_s;
        pe_psum_out  <= res_s;
      end else begin
        pe_valid_out <= 1'b0;
        pe_input_out <= {DATA_W{1'b0}};
        pe_psum_out  <= {DATA_W{1'b0}};
      end
      pe_ovf_out <= ovf_s | (pe_ovf_out & ~pe_ovf_clr_in);
    end
  end

endmodule

// File: tb/tb_pe_param.sv
// tb_pe_param: directed test of pe_param, latency-1 and latency-2 builds side by side,
// against a behavioural arithmetic model plus literal expectations.
module tb_pe_param;
  localparam int FW = 8;

  logic        clk = 1'b0;
  logic        rst, en, vin, acc, sw, clr;
  logic [15:0] din, pin, win;

  logic        o0_valid, o0_acc, o0_sw, o0_ovf;
  logic [15:0] o0_in, o0_psum, o0_wout;
  logic        o1_valid, o1_acc, o1_sw, o1_ovf;
  logic [15:0] o1_in, o1_psum, o1_wout;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef PE_SATURATE_EN
  localparam logic [15:0] EXP4  = 16'h7FFF;
  localparam logic [15:0] EXPSC = 16'h7FFF;
`else
  localparam logic [15:0] EXP4  = 16'hBC00;
  localparam logic [15:0] EXPSC = 16'h8200;
`endif

  always #5 clk = ~clk;

  pe_param #(.DATA_W(16), .FRAC_W(FW), .MUL_PIPE(0)) dut0 (
    .clk(clk), .rst(rst), .pe_enabled(en), .pe_valid_in(vin), .pe_input_in(din),
    .pe_psum_in(pin), .pe_accept_w_in(acc), .pe_weight_in(win), .pe_switch_in(sw),
    .pe_ovf_clr_in(clr), .pe_valid_out(o0_valid), .pe_input_out(o0_in),
    .pe_psum_out(o0_psum), .pe_weight_out(o0_wout), .pe_accept_w_out(o0_acc),
    .pe_switch_out(o0_sw), .pe_ovf_out(o0_ovf));

  pe_param #(.DATA_W(16), .FRAC_W(FW), .MUL_PIPE(1)) dut1 (
    .clk(clk), .rst(rst), .pe_enabled(en), .pe_valid_in(vin), .pe_input_in(din),
    .pe_psum_in(pin), .pe_accept_w_in(acc), .pe_weight_in(win), .pe_switch_in(sw),
    .pe_ovf_clr_in(clr), .pe_valid_out(o1_valid), .pe_input_out(o1_in),
    .pe_psum_out(o1_psum), .pe_weight_out(o1_wout), .pe_accept_w_out(o1_acc),
    .pe_switch_out(o1_sw), .pe_ovf_out(o1_ovf));

  typedef struct packed {
    logic        v;
    logic [15:0] inp;
    logic [15:0] ps;
    logic        ovf;
  } res_t;

  // Expected result of one input cycle, straight from the fixed-point arithmetic
  function automatic res_t mac(logic v, logic e, logic [15:0] inp, logic [15:0] ps,
                               logic [15:0] w);
    res_t   r;
    longint p;
    longint s;
    r = '0;
    if (v && e) begin
      p = longint'($signed(inp)) * longint'($signed(w));
      p = (p + (longint'(1) <<< (FW-1))) >>> FW;
      s = p + longint'($signed(ps));
      r.v   = 1'b1;
      r.inp = inp;
      r.ovf = (s > 32767) || (s < -32768);
`ifdef PE_SATURATE_EN
      if (s > 32767)       r.ps = 16'h7FFF;
      else if (s < -32768) r.ps = 16'h8000;
      else                 r.ps = s[15:0];
`else
      r.ps = s[15:0];
`endif
    end
    return r;
  endfunction

  res_t        n_now, e0, p1, e1;
  logic [15:0] m_shadow, m_active, m_wout;
  logic        m_acc, m_sw, m_ovf0, m_ovf1;
  bit          armed = 1'b0;

  always_comb n_now = mac(vin, en, din, pin, m_active);

  always @(posedge clk) begin
    if (rst) begin
      e0 <= '0; p1 <= '0; e1 <= '0;
      m_shadow <= 16'h0000; m_active <= 16'h0000; m_wout <= 16'h0000;
      m_acc <= 1'b0; m_sw <= 1'b0; m_ovf0 <= 1'b0; m_ovf1 <= 1'b0;
      armed <= 1'b1;
    end else begin
      e0 <= n_now;
      p1 <= n_now;
      e1 <= p1;
      m_ovf0 <= n_now.ovf | (m_ovf0 & ~clr);
      m_ovf1 <= p1.ovf | (m_ovf1 & ~clr);
      if (sw)  m_active <= m_shadow;
      if (acc) m_shadow <= win;
      m_wout <= win;
      m_acc  <= acc;
      m_sw   <= sw;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        chk("m0_valid", o0_valid, e0.v);   chk("m0_input", o0_in, e0.inp);
        chk("m0_psum", o0_psum, e0.ps);    chk("m0_ovf", o0_ovf, m_ovf0);
        chk("m0_wout", o0_wout, m_wout);   chk("m0_acc", o0_acc, m_acc);
        chk("m0_sw", o0_sw, m_sw);
        chk("m1_valid", o1_valid, e1.v);   chk("m1_input", o1_in, e1.inp);
        chk("m1_psum", o1_psum, e1.ps);    chk("m1_ovf", o1_ovf, m_ovf1);
        chk("m1_wout", o1_wout, m_wout);   chk("m1_acc", o1_acc, m_acc);
        chk("m1_sw", o1_sw, m_sw);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic e, input logic [15:0] d, input logic [15:0] p,
                       input logic a, input logic [15:0] w, input logic s, input logic c);
    vin = v; en = e; din = d; pin = p; acc = a; win = w; sw = s; clr = c;
  endtask

  typedef struct packed { logic [15:0] w; logic [15:0] d; logic [15:0] p; } vec_t;
  vec_t vt [4];

  initial begin
    vt[0] = {16'h8000, 16'h0200, 16'h0000};
    vt[1] = {16'hFF00, 16'hFF00, 16'h8000};
    vt[2] = {16'h0123, 16'h0456, 16'hF000};
    vt[3] = {16'h7FFF, 16'h7FFF, 16'h7FFF};

    rst = 1'b1;
    drive(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    tick(); tick();
    chk("rst_valid0", o0_valid, 16'h0000); chk("rst_psum1", o1_psum, 16'h0000);
    chk("rst_wout", o0_wout, 16'h0000);    chk("rst_ovf1", o1_ovf, 16'h0000);
    rst = 1'b0;

    drive(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 16'h4500, 1'b0, 1'b0); tick();
    chk("t1_wout", o0_wout, 16'h4500); chk("t1_acc", o0_acc, 16'h0001);

    drive(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 16'h0A00, 1'b1, 1'b0); tick();
    chk("t2_sw", o0_sw, 16'h0001); chk("t2_wout", o0_wout, 16'h0A00);

    drive(1'b1, 1'b1, 16'h0200, 16'h3200, 1'b0, 16'h0000, 1'b0, 1'b0); tick();
    chk("t4_psum0", o0_psum, EXP4); chk("t4_ovf0", o0_ovf, 16'h0001);
    drive(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0); tick();
    chk("t4_psum1", o1_psum, EXP4);  chk("t4_ovf1", o1_ovf, 16'h0001);
    chk("t4_sticky0", o0_ovf, 16'h0001); chk("t4_idle0", o0_psum, 16'h0000);
    tick();
    chk("t4_hold0", o0_ovf, 16'h0001);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_ovf0", o0_ovf, 16'h0000); chk("clr_ovf1", o1_ovf, 16'h0000);

    // valid alongside accept+switch still uses 0x4500; next valid uses old shadow 0x0A00
    drive(1'b1, 1'b1, 16'h0100, 16'h0000, 1'b1, 16'h0180, 1'b1, 1'b0); tick();
    chk("sw_old_act", o0_psum, 16'h4500);
    drive(1'b1, 1'b1, 16'h0100, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0); tick();
    chk("sw_old_shadow", o0_psum, 16'h0A00);
    drive(1'b1, 1'b1, 16'hFE00, 16'h0040, 1'b0, 16'h0000, 1'b0, 1'b0); tick();
    chk("t3_psum0", o0_psum, 16'hFD40); chk("t3_in0", o0_in, 16'hFE00);
    chk("t3_valid0", o0_valid, 16'h0001); chk("t3_ovf0", o0_ovf, 16'h0000);
    drive(1'b1, 1'b1, 16'h0200, 16'h7F00, 1'b0, 16'h0000, 1'b0, 1'b1); tick();
    chk("t3_psum1", o1_psum, 16'hFD40);
    chk("setclr_ovf0", o0_ovf, 16'h0001); chk("setclr_psum0", o0_psum, EXPSC);
    drive(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1); tick(); tick();
    clr = 1'b0;

    drive(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0); tick();
    drive(1'b1, 1'b1, 16'h0080, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0); tick();
    chk("t5_round_up", o0_psum, 16'h0001);
    drive(1'b1, 1'b1, 16'hFF80, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0); tick();
    chk("t5_round_neg", o0_psum, 16'h0000);

    foreach (vt[i]) begin
      drive(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, vt[i].w, 1'b0, 1'b1); tick();
      drive(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0); tick();
      drive(1'b1, 1'b1, vt[i].d, vt[i].p, 1'b0, 16'h0000, 1'b0, 1'b0); tick();
    end

    drive(1'b1, 1'b0, 16'h1111, 16'h2222, 1'b1, 16'h1234, 1'b0, 1'b0); tick();
    chk("dis_valid0", o0_valid, 16'h0000); chk("dis_psum0", o0_psum, 16'h0000);
    chk("dis_wout", o0_wout, 16'h1234);    chk("dis_acc", o0_acc, 16'h0001);
    drive(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0); tick();
    chk("dis_valid1", o1_valid, 16'h0000);

    drive(1'b1, 1'b1, 16'h0100, 16'h0010, 1'b0, 16'h0000, 1'b0, 1'b0);
    tick(); tick(); tick();
    chk("inflight_valid1", o1_valid, 16'h0001);
    rst = 1'b1; tick();
    chk("rst_fl_valid1", o1_valid, 16'h0000); chk("rst_fl_psum1", o1_psum, 16'h0000);
    rst = 1'b0; vin = 1'b0; tick();
    chk("rst_fl_valid1b", o1_valid, 16'h0000);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
